// File: rtl/fft_stage_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fft_stage_seq_ctrl
// Sequencer for the last FFT stage (input butterfly pair -> sat3 output
// saturators -> output registers). A single FSM replaces the old enable-delay
// flop chain and switch counter. From the input valid stream it derives the
// stage enable and the butterfly commutator select. It also produces the
// output valid and frame markers, and flags frame-sync errors.
//
// Optional feature macro: FFT_SEQ_STATS_EN adds the o_frame_cnt / o_err_cnt
// saturating statistics counters.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous, active-high reset
//   i_in_valid   upstream sample-group valid
//   i_in_sof     first group of an input frame (qualified by i_in_valid)
//   o_stage_en   datapath enable for the butterfly stage
//   o_bf_ctrl    butterfly commutator select
//   o_out_valid  output registers hold valid data
//   o_out_sof    first output cycle of a frame
//   o_out_eof    last output cycle of a frame
//   o_sync_err   1-cycle pulse: in_sof at an unexpected position
//   o_busy       FSM not IDLE, or output valid pipe non-empty
//   o_frame_cnt  (stats) completed output frames, saturating
//   o_err_cnt    (stats) sync_err pulses, saturating
// ---------------------------------------------------------------------------
module fft_stage_seq_ctrl #(
   parameter int PIPE_DLY  = 18,
   parameter int HALF_PER  = 16,
   parameter int OUT_LAT   = 17,
   parameter int FRAME_CYC = 32,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   input  logic             i_in_sof,
   output logic             o_stage_en,
   output logic             o_bf_ctrl,
   output logic             o_out_valid,
   output logic             o_out_sof,
   output logic             o_out_eof,
   output logic             o_sync_err,
   output logic             o_busy
`ifdef FFT_SEQ_STATS_EN
   ,
   output logic [CNT_W-1:0] o_frame_cnt,
   output logic [CNT_W-1:0] o_err_cnt
`endif
);

   localparam int SC_W = 5;                       // shared FSM counter
   localparam int PH_W = $clog2(2*HALF_PER);      // bf_ctrl phase counter
   localparam int FC_W = $clog2(FRAME_CYC);       // frame position counters
   // r_out_valid is the last stage of the valid delay, so the pipe itself
   // holds OUT_LAT-1 bits.
   localparam int VP_W = OUT_LAT - 1;
   // Resync tag covers input -> stage_en -> out_valid, one stage short so the
   // registered sof/eof decode lands on the realigned output cycle.
   localparam int TP_W = PIPE_DLY + OUT_LAT - 1;

   typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

   state_t            r_state;
   logic [SC_W-1:0]   r_cnt;
   logic              r_stage_en;
   logic [PH_W-1:0]   r_phase;
   logic [VP_W-1:0]   r_vpipe;
   logic [TP_W-1:0]   r_tpipe;
   logic              r_out_valid;
   logic              r_out_sof;
   logic              r_out_eof;
   logic [FC_W-1:0]   r_ocnt;
   logic [FC_W-1:0]   r_icnt;
   logic              r_sync_err;

   logic              w_sof_err;
   logic [FC_W-1:0]   w_ocnt;

   // ---------------- control FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_stage_en <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_in_valid && i_in_sof) begin
                  r_state <= FILL;
                  r_cnt   <= SC_W'(1);
               end
            end
            FILL: begin
               if (!i_in_valid) begin
                  // Upstream stopped before the pipeline filled: drop it.
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == SC_W'(PIPE_DLY-1)) begin
                  r_state    <= RUN;
                  r_cnt      <= '0;
                  r_stage_en <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RUN: begin
               if (!i_in_valid) begin
                  r_state <= DRAIN;
                  r_cnt   <= '0;
               end
            end
            DRAIN: begin
               // Data resuming inside the drain window continues the frame;
               // the phase counters are untouched.
               if (i_in_valid) begin
                  r_state <= RUN;
               end else if (r_cnt == SC_W'(PIPE_DLY-1)) begin
                  r_state    <= IDLE;
                  r_cnt      <= '0;
                  r_stage_en <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_cnt      <= '0;
               r_stage_en <= 1'b0;
            end
         endcase
      end
   end

   // ---------------- butterfly commutator phase ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst || r_state == IDLE)
         r_phase <= '0;
      else if (r_stage_en)
         r_phase <= r_phase + 1'b1;
   end

   // ---------------- input frame sync check ----------------
   assign w_sof_err = (r_state != IDLE) && i_in_valid && i_in_sof && (r_icnt != '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_icnt     <= '0;
         r_sync_err <= 1'b0;
      end else begin
         r_sync_err <= w_sof_err;
         if (r_state == IDLE)
            r_icnt <= (i_in_valid && i_in_sof) ? FC_W'(1) : '0;
         else if (i_in_valid) begin
            if (i_in_sof)
               r_icnt <= FC_W'(1);
            else if (r_icnt == FC_W'(FRAME_CYC-1))
               r_icnt <= '0;
            else
               r_icnt <= r_icnt + 1'b1;
         end
      end
   end

   // ---------------- output valid / frame markers ----------------
   // A tag emerging from the resync pipe forces this output to frame start.
   assign w_ocnt = r_tpipe[TP_W-1] ? '0 : r_ocnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vpipe     <= '0;
         r_tpipe     <= '0;
         r_out_valid <= 1'b0;
         r_out_sof   <= 1'b0;
         r_out_eof   <= 1'b0;
         r_ocnt      <= '0;
      end else begin
         r_vpipe     <= {r_vpipe[VP_W-2:0], r_stage_en};
         r_tpipe     <= {r_tpipe[TP_W-2:0], w_sof_err};
         r_out_valid <= r_vpipe[VP_W-1];
         if (r_vpipe[VP_W-1]) begin
            r_out_sof <= (w_ocnt == '0);
            r_out_eof <= (w_ocnt == FC_W'(FRAME_CYC-1));
            r_ocnt    <= (w_ocnt == FC_W'(FRAME_CYC-1)) ? '0 : w_ocnt + 1'b1;
         end else begin
            r_out_sof <= 1'b0;
            r_out_eof <= 1'b0;
            if (~|r_vpipe)
               r_ocnt <= '0;
         end
      end
   end

`ifdef FFT_SEQ_STATS_EN
   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (r_out_eof && r_frame_cnt != '1)
            r_frame_cnt <= r_frame_cnt + 1'b1;
         if (r_sync_err && r_err_cnt != '1)
            r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign o_frame_cnt = r_frame_cnt;
   assign o_err_cnt   = r_err_cnt;
`endif

   assign o_stage_en  = r_stage_en;
   assign o_bf_ctrl   = r_phase[PH_W-1];
   assign o_out_valid = r_out_valid;
   assign o_out_sof   = r_out_sof;
   assign o_out_eof   = r_out_eof;
   assign o_sync_err  = r_sync_err;
   assign o_busy      = (r_state != IDLE) || (|r_vpipe) || r_out_valid;

endmodule
